// File: rtl/axi_ctrl_pkg.sv
// Shared constants for the AXI control window bridge.
//   Response codes and burst encodings (AXI3), write/read FSM state
//   encodings, and the per-transaction legality/decode response helper.
package axi_ctrl_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] W_IDLE = 2'd0;
  localparam logic [1:0] W_DATA = 2'd1;
  localparam logic [1:0] W_REQ  = 2'd2;
  localparam logic [1:0] W_RESP = 2'd3;

  localparam logic [2:0] R_IDLE = 3'd0;
  localparam logic [2:0] R_REQ  = 3'd1;
  localparam logic [2:0] R_WAIT = 3'd2;
  localparam logic [2:0] R_DATA = 3'd3;
  localparam logic [2:0] R_ERR  = 3'd4;

  // Response chosen at address-phase time. An unmapped address reports
  // DECERR even when the burst is also illegal.
  function automatic logic [1:0] txn_resp(input logic       hit,
                                          input logic [1:0] burst,
                                          input logic [2:0] size,
                                          input logic [2:0] max_size);
    if (!hit) return RESP_DECERR;
    if (burst != BURST_FIXED && burst != BURST_INCR) return RESP_SLVERR;
    if (size > max_size) return RESP_SLVERR;
    return RESP_OKAY;
  endfunction

endpackage

// File: rtl/axi_ctrl_window_decode.sv
// Combinational priority window matcher.
//   i_addr   : address to decode
//   o_hit    : some window matched
//   o_win    : index of the lowest-numbered matching window
//   o_offset : i_addr with the matching window's mask bits cleared
module axi_ctrl_window_decode #(
  parameter int ADDR_WIDTH  = 32,
  parameter int NUM_WINDOWS = 2,
  parameter int WIN_W       = 1,
  parameter logic [NUM_WINDOWS*ADDR_WIDTH-1:0] WINDOW_BASE = {32'h6e410000, 32'h6e400000},
  parameter logic [NUM_WINDOWS*ADDR_WIDTH-1:0] WINDOW_MASK = {32'hffff0000, 32'hffff0000}
) (
  input  logic [ADDR_WIDTH-1:0] i_addr,
  output logic                  o_hit,
  output logic [WIN_W-1:0]      o_win,
  output logic [ADDR_WIDTH-1:0] o_offset
);

  // Scan from the top down so the lowest matching index is written last.
  always_comb begin
    o_hit    = 1'b0;
    o_win    = '0;
    o_offset = '0;
    for (int i = NUM_WINDOWS - 1; i >= 0; i--) begin
      if ((i_addr & WINDOW_MASK[i*ADDR_WIDTH +: ADDR_WIDTH]) ==
          WINDOW_BASE[i*ADDR_WIDTH +: ADDR_WIDTH]) begin
        o_hit    = 1'b1;
        o_win    = WIN_W'(i);
        o_offset = i_addr & ~WINDOW_MASK[i*ADDR_WIDTH +: ADDR_WIDTH];
      end
    end
  end

endmodule

// File: rtl/axi_ctrl_window_bridge.sv
// AXI3 slave turning control-port bursts into valid/ready request streams.
//   CLK/RST       : clock, synchronous active-high reset
//   aw*/w*/b*     : AXI write address, data and response channels
//   ar*/r*        : AXI read address and data channels
//   wr_req_*      : one downstream write request per mapped write beat
//   rd_req_*      : one downstream read request per mapped read beat
//   rd_rsp_*      : single-cycle read data return, no backpressure
//
// Write FSM
//   state  | meaning
//   W_IDLE | awready=1, waiting for an address
//   W_DATA | wready=1, capturing (or draining) one beat
//   W_REQ  | wr_req_valid=1 until wr_req_ready
//   W_RESP | bvalid=1 until bready
// Read FSM
//   state  | meaning
//   R_IDLE | arready=1, waiting for an address
//   R_REQ  | rd_req_valid=1 until rd_req_ready
//   R_WAIT | waiting for the rd_rsp_valid pulse
//   R_DATA | rvalid=1 with captured data until rready
//   R_ERR  | rvalid=1 with zero data and error rresp until rready
module axi_ctrl_window_bridge
  import axi_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int ID_WIDTH    = 12,
  parameter int NUM_WINDOWS = 2,
  parameter logic [NUM_WINDOWS*ADDR_WIDTH-1:0] WINDOW_BASE = {32'h6e410000, 32'h6e400000},
  parameter logic [NUM_WINDOWS*ADDR_WIDTH-1:0] WINDOW_MASK = {32'hffff0000, 32'hffff0000},
  localparam int WIN_W  = (NUM_WINDOWS > 1) ? $clog2(NUM_WINDOWS) : 1,
  localparam int STRB_W = DATA_WIDTH / 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [ID_WIDTH-1:0]   awid,
  input  logic [ADDR_WIDTH-1:0] awaddr,
  input  logic [3:0]            awlen,
  input  logic [2:0]            awsize,
  input  logic [1:0]            awburst,
  input  logic                  awvalid,
  output logic                  awready,
  input  logic [ID_WIDTH-1:0]   wid,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [STRB_W-1:0]     wstrb,
  input  logic                  wlast,
  input  logic                  wvalid,
  output logic                  wready,
  output logic [ID_WIDTH-1:0]   bid,
  output logic [1:0]            bresp,
  output logic                  bvalid,
  input  logic                  bready,
  input  logic [ID_WIDTH-1:0]   arid,
  input  logic [ADDR_WIDTH-1:0] araddr,
  input  logic [3:0]            arlen,
  input  logic [2:0]            arsize,
  input  logic [1:0]            arburst,
  input  logic                  arvalid,
  output logic                  arready,
  output logic [ID_WIDTH-1:0]   rid,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic [1:0]            rresp,
  output logic                  rlast,
  output logic                  rvalid,
  input  logic                  rready,
  output logic                  wr_req_valid,
  input  logic                  wr_req_ready,
  output logic [WIN_W-1:0]      wr_req_win,
  output logic [ADDR_WIDTH-1:0] wr_req_addr,
  output logic [DATA_WIDTH-1:0] wr_req_data,
  output logic [STRB_W-1:0]     wr_req_strb,
  output logic                  rd_req_valid,
  input  logic                  rd_req_ready,
  output logic [WIN_W-1:0]      rd_req_win,
  output logic [ADDR_WIDTH-1:0] rd_req_addr,
  input  logic                  rd_rsp_valid,
  input  logic [DATA_WIDTH-1:0] rd_rsp_data
);

  localparam logic [2:0] MAX_SIZE = 3'($clog2(STRB_W));

  // Beats are matched by count and ordering; the W-channel ID is not checked.
  logic w_unused_wid;
  assign w_unused_wid = ^wid;

  function automatic logic [ADDR_WIDTH-1:0] win_mask(input logic [WIN_W-1:0] win);
    win_mask = '0;
    for (int i = 0; i < NUM_WINDOWS; i++) begin
      if (win == WIN_W'(i)) win_mask = WINDOW_MASK[i*ADDR_WIDTH +: ADDR_WIDTH];
    end
  endfunction

  // ---------------- write path ----------------
  logic                  w_aw_hit;
  logic [WIN_W-1:0]      w_aw_win;
  logic [ADDR_WIDTH-1:0] w_aw_off;
  logic [1:0]            w_aw_resp;
  logic                  w_w_last;
  logic [ADDR_WIDTH-1:0] w_aw_next;

  logic [1:0]            r_w_state;
  logic [ID_WIDTH-1:0]   r_aw_id;
  logic [ADDR_WIDTH-1:0] r_aw_addr;
  logic [ADDR_WIDTH-1:0] r_aw_off;
  logic [3:0]            r_aw_len;
  logic [2:0]            r_aw_size;
  logic [1:0]            r_aw_burst;
  logic [WIN_W-1:0]      r_aw_win;
  logic                  r_aw_err;
  logic [1:0]            r_bresp;
  logic [3:0]            r_w_cnt;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [STRB_W-1:0]     r_wstrb;

  axi_ctrl_window_decode #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .NUM_WINDOWS(NUM_WINDOWS),
    .WIN_W      (WIN_W),
    .WINDOW_BASE(WINDOW_BASE),
    .WINDOW_MASK(WINDOW_MASK)
  ) u_aw_decode (
    .i_addr  (awaddr),
    .o_hit   (w_aw_hit),
    .o_win   (w_aw_win),
    .o_offset(w_aw_off)
  );

  assign w_aw_resp = txn_resp(w_aw_hit, awburst, awsize, MAX_SIZE);
  assign w_w_last  = (r_w_cnt == r_aw_len);
  assign w_aw_next = (r_aw_burst == BURST_INCR) ?
                     r_aw_addr + (ADDR_WIDTH'(1) << r_aw_size) : r_aw_addr;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_w_state  <= W_IDLE;
      r_aw_id    <= '0;
      r_aw_addr  <= '0;
      r_aw_off   <= '0;
      r_aw_len   <= '0;
      r_aw_size  <= '0;
      r_aw_burst <= '0;
      r_aw_win   <= '0;
      r_aw_err   <= 1'b0;
      r_bresp    <= RESP_OKAY;
      r_w_cnt    <= '0;
      r_wdata    <= '0;
      r_wstrb    <= '0;
    end else begin
      case (r_w_state)
        W_IDLE: if (awvalid) begin
          r_aw_id    <= awid;
          r_aw_addr  <= awaddr;
          r_aw_off   <= w_aw_off;
          r_aw_len   <= awlen;
          r_aw_size  <= awsize;
          r_aw_burst <= awburst;
          r_aw_win   <= w_aw_win;
          r_aw_err   <= (w_aw_resp != RESP_OKAY);
          r_bresp    <= w_aw_resp;
          r_w_cnt    <= '0;
          r_w_state  <= W_DATA;
        end
        W_DATA: if (wvalid) begin
          r_wdata <= wdata;
          r_wstrb <= wstrb;
          // wlast disagreeing with the beat count is reported but never
          // shortens or extends the burst.
          if ((wlast != w_w_last) && (r_bresp != RESP_DECERR)) r_bresp <= RESP_SLVERR;
          if (r_aw_err) begin
            if (w_w_last) r_w_state <= W_RESP;
            else          r_w_cnt   <= r_w_cnt + 4'd1;
          end else begin
            r_w_state <= W_REQ;
          end
        end
        W_REQ: if (wr_req_ready) begin
          if (w_w_last) begin
            r_w_state <= W_RESP;
          end else begin
            r_w_cnt   <= r_w_cnt + 4'd1;
            r_aw_addr <= w_aw_next;
            r_aw_off  <= w_aw_next & ~win_mask(r_aw_win);
            r_w_state <= W_DATA;
          end
        end
        W_RESP: if (bready) r_w_state <= W_IDLE;
        default: r_w_state <= W_IDLE;
      endcase
    end
  end

  assign awready      = (r_w_state == W_IDLE);
  assign wready       = (r_w_state == W_DATA);
  assign wr_req_valid = (r_w_state == W_REQ);
  assign bvalid       = (r_w_state == W_RESP);
  assign bid          = r_aw_id;
  assign bresp        = r_bresp;
  assign wr_req_win   = r_aw_win;
  assign wr_req_addr  = r_aw_off;
  assign wr_req_data  = r_wdata;
  assign wr_req_strb  = r_wstrb;

  // ---------------- read path ----------------
  logic                  w_ar_hit;
  logic [WIN_W-1:0]      w_ar_win;
  logic [ADDR_WIDTH-1:0] w_ar_off;
  logic [1:0]            w_ar_resp;
  logic                  w_r_last;
  logic [ADDR_WIDTH-1:0] w_ar_next;

  logic [2:0]            r_r_state;
  logic [ID_WIDTH-1:0]   r_ar_id;
  logic [ADDR_WIDTH-1:0] r_ar_addr;
  logic [ADDR_WIDTH-1:0] r_ar_off;
  logic [3:0]            r_ar_len;
  logic [2:0]            r_ar_size;
  logic [1:0]            r_ar_burst;
  logic [WIN_W-1:0]      r_ar_win;
  logic [1:0]            r_rresp;
  logic [3:0]            r_r_cnt;
  logic [DATA_WIDTH-1:0] r_rdata;

  axi_ctrl_window_decode #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .NUM_WINDOWS(NUM_WINDOWS),
    .WIN_W      (WIN_W),
    .WINDOW_BASE(WINDOW_BASE),
    .WINDOW_MASK(WINDOW_MASK)
  ) u_ar_decode (
    .i_addr  (araddr),
    .o_hit   (w_ar_hit),
    .o_win   (w_ar_win),
    .o_offset(w_ar_off)
  );

  assign w_ar_resp = txn_resp(w_ar_hit, arburst, arsize, MAX_SIZE);
  assign w_r_last  = (r_r_cnt == r_ar_len);
  assign w_ar_next = (r_ar_burst == BURST_INCR) ?
                     r_ar_addr + (ADDR_WIDTH'(1) << r_ar_size) : r_ar_addr;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_r_state  <= R_IDLE;
      r_ar_id    <= '0;
      r_ar_addr  <= '0;
      r_ar_off   <= '0;
      r_ar_len   <= '0;
      r_ar_size  <= '0;
      r_ar_burst <= '0;
      r_ar_win   <= '0;
      r_rresp    <= RESP_OKAY;
      r_r_cnt    <= '0;
      r_rdata    <= '0;
    end else begin
      case (r_r_state)
        R_IDLE: if (arvalid) begin
          r_ar_id    <= arid;
          r_ar_addr  <= araddr;
          r_ar_off   <= w_ar_off;
          r_ar_len   <= arlen;
          r_ar_size  <= arsize;
          r_ar_burst <= arburst;
          r_ar_win   <= w_ar_win;
          r_rresp    <= w_ar_resp;
          r_r_cnt    <= '0;
          r_rdata    <= '0;   // error beats return zero data
          r_r_state  <= (w_ar_resp != RESP_OKAY) ? R_ERR : R_REQ;
        end
        R_REQ: if (rd_req_ready) r_r_state <= R_WAIT;
        R_WAIT: if (rd_rsp_valid) begin
          r_rdata   <= rd_rsp_data;
          r_r_state <= R_DATA;
        end
        R_DATA: if (rready) begin
          if (w_r_last) begin
            r_r_state <= R_IDLE;
          end else begin
            r_r_cnt   <= r_r_cnt + 4'd1;
            r_ar_addr <= w_ar_next;
            r_ar_off  <= w_ar_next & ~win_mask(r_ar_win);
            r_r_state <= R_REQ;
          end
        end
        R_ERR: if (rready) begin
          if (w_r_last) r_r_state <= R_IDLE;
          else          r_r_cnt   <= r_r_cnt + 4'd1;
        end
        default: r_r_state <= R_IDLE;
      endcase
    end
  end

  assign arready      = (r_r_state == R_IDLE);
  assign rd_req_valid = (r_r_state == R_REQ);
  assign rvalid       = (r_r_state == R_DATA) || (r_r_state == R_ERR);
  assign rlast        = rvalid && w_r_last;
  assign rid          = r_ar_id;
  assign rdata        = r_rdata;
  assign rresp        = r_rresp;
  assign rd_req_win   = r_ar_win;
  assign rd_req_addr  = r_ar_off;

endmodule
